// File: rtl/pulse_seq_pkg.sv
// Shared types and default widths for the pulse burst controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pulse_seq_pkg;

  localparam int PERIOD_W_DEF = 8;
  localparam int COUNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_period_timer.sv
// Runtime-period free-running counter; tick marks the last count of each period.
// Latency: tick is combinational from the registered count; first tick period-1 cycles after clear.
// Backpressure: none; en gates counting, clear restarts from zero.
//
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clear      : restart the count at 0 (takes priority over en)
//   en         : advance the count this cycle
//   period     : period in cycles, must be >= 1
//   tick       : high while cnt == period-1
module pulse_period_timer
  import pulse_seq_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] cnt;

  assign tick = (cnt == (period - PERIOD_W'(1)));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/pulse_seq_ctrl.sv
// Counted, abortable burst of single-cycle pulses, one every P cycles, started by a command.
// Latency: first pulse P cycles after accept; done one cycle after the final pulse or abort.
// Backpressure: cmd_ready only in IDLE (and not in reset); commands outside IDLE are ignored.
//
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake carrying cmd_period (P) and cmd_count (N)
//   abort                 : end the active burst early (only looked at in RUN)
//   signal                : pulse output
//   busy                  : burst in progress
//   done / aborted        : one-cycle completion strobe, aborted qualifies it
//   pulse_idx             : pulses emitted in the current or last burst
//
// Build option: PULSE_SEQ_INFINITE_EN makes cmd_count==0 an unbounded burst that only
// abort can end; without it cmd_count==0 completes immediately with no pulses.
module pulse_seq_ctrl
  import pulse_seq_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int COUNT_W  = COUNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic [COUNT_W-1:0]  cmd_count,
  input  logic                abort,
  output logic                signal,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [COUNT_W-1:0]  pulse_idx
);

  state_t              state;
  logic [PERIOD_W-1:0] period_q;
  logic [COUNT_W-1:0]  count_q;
  logic                inf_q;
  logic                busy_q;
  logic                done_q;
  logic                aborted_q;

  logic                accept;
  logic                tick;
  logic                final_pulse;
  logic                zero_len;
  logic [PERIOD_W-1:0] period_clamped;

  assign cmd_ready = (state == IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;

  // 0 and 1 both mean "every cycle"; the timer needs period >= 1.
  assign period_clamped = (cmd_period < PERIOD_W'(2)) ? PERIOD_W'(1) : cmd_period;

`ifdef PULSE_SEQ_INFINITE_EN
  assign zero_len = 1'b0;
`else
  assign zero_len = (cmd_count == '0);
`endif

  pulse_period_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .en     (state == RUN),
    .period (period_q),
    .tick   (tick)
  );

  assign signal = (state == RUN) && tick;

  // An unbounded burst never has a final pulse, so pulse_idx may wrap freely.
  assign final_pulse = signal && !inf_q && (pulse_idx == (count_q - COUNT_W'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      period_q  <= PERIOD_W'(1);
      count_q   <= '0;
      inf_q     <= 1'b0;
      pulse_idx <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            period_q  <= period_clamped;
            count_q   <= cmd_count;
            pulse_idx <= '0;
`ifdef PULSE_SEQ_INFINITE_EN
            inf_q     <= (cmd_count == '0);
`else
            inf_q     <= 1'b0;
`endif
            if (zero_len) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state  <= RUN;
              busy_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (signal) begin
            pulse_idx <= pulse_idx + COUNT_W'(1);
          end
          // A pulse coincident with abort still counts; if it was the last one
          // the burst is reported as a normal completion.
          if (final_pulse || abort) begin
            state     <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            aborted_q <= abort && !final_pulse;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
module tb_pulse_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_period;
  logic [7:0] cmd_count;
  logic       abort;
  logic       signal;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [7:0] pulse_idx;

  int tests = 0;
  int fails = 0;

  // Per-cycle logs, bit k = cycle A+k after the accept cycle A.
  logic [63:0] sig_log, done_log, ab_log, busy_log, rdy_log;

  pulse_seq_ctrl #(.PERIOD_W(8), .COUNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_period (cmd_period),
    .cmd_count  (cmd_count),
    .abort      (abort),
    .signal     (signal),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .pulse_idx  (pulse_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a command in the current cycle A (called at a falling edge).
  task automatic issue(input string tag, input logic [7:0] p, input logic [7:0] n);
    @(negedge clk);
    chk({tag, "_ready_at_A"}, 64'(cmd_ready), 64'd1);
    cmd_valid  = 1'b1;
    cmd_period = p;
    cmd_count  = n;
  endtask

  // Observe cycles A+1..A+ncyc. Outputs are sampled first at each falling edge,
  // then the inputs for that cycle are driven.
  task automatic watch(input int ncyc, input int hold, input int abort_k, input int reset_k);
    sig_log = '0; done_log = '0; ab_log = '0; busy_log = '0; rdy_log = '0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      sig_log[k]  = signal;
      done_log[k] = done;
      ab_log[k]   = aborted;
      busy_log[k] = busy;
      rdy_log[k]  = cmd_ready;
      if (k <= hold) begin
        cmd_period = 8'd2;
        cmd_count  = 8'd7;
      end else begin
        cmd_valid = 1'b0;
      end
      abort = (k == abort_k);
      if (reset_k > 0) reset = (k >= reset_k) && (k < reset_k + 2);
    end
  endtask

  task automatic check_burst(input string tag, input logic [63:0] e_sig, input logic [63:0] e_done,
                             input logic [63:0] e_ab, input logic [63:0] e_busy,
                             input logic [63:0] e_rdy, input logic [7:0] e_idx);
    chk({tag, "_signal"},  sig_log,  e_sig);
    chk({tag, "_done"},    done_log, e_done);
    chk({tag, "_aborted"}, ab_log,   e_ab);
    chk({tag, "_busy"},    busy_log, e_busy);
    chk({tag, "_ready"},   rdy_log,  e_rdy);
    chk({tag, "_idx"},     64'(pulse_idx), 64'(e_idx));
  endtask

`ifdef PULSE_SEQ_INFINITE_EN
  int npulse;
  logic saw_done, saw_ab;
`endif

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_period = 8'd0;
    cmd_count  = 8'd0;
    abort      = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready",   64'(cmd_ready), 64'd0);
    chk("rst_signal",  64'(signal),    64'd0);
    chk("rst_busy",    64'(busy),      64'd0);
    chk("rst_done",    64'(done),      64'd0);
    chk("rst_aborted", 64'(aborted),   64'd0);
    chk("rst_idx",     64'(pulse_idx), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rel_ready", 64'(cmd_ready), 64'd1);
    repeat (5) @(negedge clk);

    // P=5, N=3: pulses at A+5, A+10, A+15; done A+16; ready again A+17
    issue("p5n3", 8'd5, 8'd3);
    watch(17, 0, 0, 0);
    check_burst("p5n3", 64'h8420, 64'h10000, 64'h0, 64'hFFFE, 64'h20000, 8'd3);

    // P=0 and P=1, N=4: pulses A+1..A+4, done A+5
    issue("p0n4", 8'd0, 8'd4);
    watch(6, 0, 0, 0);
    check_burst("p0n4", 64'h1E, 64'h20, 64'h0, 64'h1E, 64'h40, 8'd4);
    issue("p1n4", 8'd1, 8'd4);
    watch(6, 0, 0, 0);
    check_burst("p1n4", 64'h1E, 64'h20, 64'h0, 64'h1E, 64'h40, 8'd4);

    // P=4, N=10, abort in A+9: pulses A+4, A+8; done+aborted A+10
    issue("abort", 8'd4, 8'd10);
    watch(11, 0, 9, 0);
    check_burst("abort", 64'h110, 64'h400, 64'h400, 64'h3FE, 64'h800, 8'd2);

    // P=3, N=2, abort with the final pulse in A+6: normal completion
    issue("abfin", 8'd3, 8'd2);
    watch(8, 0, 6, 0);
    check_burst("abfin", 64'h48, 64'h80, 64'h0, 64'h7E, 64'h100, 8'd2);

    // cmd_valid held through RUN with other P/N: burst unchanged
    issue("hold", 8'd5, 8'd3);
    watch(17, 15, 0, 0);
    check_burst("hold", 64'h8420, 64'h10000, 64'h0, 64'hFFFE, 64'h20000, 8'd3);

    // Reset raised in A+7 for two cycles: only the A+5 pulse, no done
    issue("rstmid", 8'd5, 8'd3);
    watch(14, 0, 0, 7);
    check_burst("rstmid", 64'h20, 64'h0, 64'h0, 64'hFE, 64'h7C00, 8'd0);

`ifndef PULSE_SEQ_INFINITE_EN
    // N=0: done in A+1, no pulses
    issue("n0", 8'd3, 8'd0);
    watch(2, 0, 0, 0);
    check_burst("n0", 64'h0, 64'h2, 64'h0, 64'h0, 64'h4, 8'd0);
`else
    // N=0 unbounded, P=2: pulses on even cycles; abort with pulse 310 in A+620
    issue("inf", 8'd2, 8'd0);
    npulse = 0; saw_done = 1'b0; saw_ab = 1'b0;
    for (int k = 1; k <= 622; k++) begin
      @(negedge clk);
      if (signal) npulse++;
      if (k == 621) begin
        saw_done = done;
        saw_ab   = aborted;
      end
      cmd_valid = 1'b0;
      abort = (k == 620);
    end
    chk("inf_pulses",  64'(npulse),    64'd310);
    chk("inf_done",    64'(saw_done),  64'd1);
    chk("inf_aborted", 64'(saw_ab),    64'd1);
    chk("inf_idx",     64'(pulse_idx), 64'd54);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pulse_seq_ctrl.md
# pulse_seq_ctrl

Burst controller for the periodic pulse datapath. Accepts a command (period, pulse count) over a valid/ready handshake, then emits exactly that many single-cycle pulses on `signal`, one every `period` cycles, and reports completion. It sits between a software/config requester and any consumer of a strobe/tick. It generalises the fixed-period generator to runtime-programmable, counted, abortable bursts.

## Interface
- `PERIOD_W`, default 8: width of `cmd_period` and the internal period counter.
- `COUNT_W`, default 8: width of `cmd_count` and `pulse_idx`.

Ports:
- `clk`  in  1: single clock, all logic on rising edge.
- `reset`  in  1: synchronous, active-high.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: high only in IDLE with `reset` low.
- `cmd_period`  in  PERIOD_W: pulse spacing P in cycles. Values 0 and 1 both mean every cycle.
- `cmd_count`  in  COUNT_W: number of pulses N.
- `abort`  in  1: stop the active burst.
- `signal`  out  1: pulse output, one cycle wide.
- `busy`  out  1: high in RUN.
- `done`  out  1: one-cycle completion strobe.
- `aborted`  out  1: qualifies `done`. High when the burst ended via `abort`.
- `pulse_idx`  out  COUNT_W: pulses emitted in the current or last burst.

## Operation
- FSM states and transitions:
  - IDLE → RUN on accept when N≠0.
  - IDLE → DONE on accept when N=0.
  - RUN → DONE after the final pulse, or on abort.
  - DONE → IDLE unconditionally.
- Accept: `cmd_valid && cmd_ready` at a rising edge. On accept:
  - P is latched, with values <2 clamped to 1.
  - N is latched.
  - The period counter is cleared to 0.
  - `pulse_idx` is cleared to 0.
- Period counter in RUN:
  - Counts 0..P-1, then wraps to 0.
  - `signal = (state==RUN) && (cnt==P-1)`. This is combinational from registered state.
- Each pulse increments `pulse_idx`. It holds in DONE/IDLE until the next accept.
- The final pulse is the one where `pulse_idx==N-1`.
- `done` is high only in DONE state. `aborted` is valid only while `done` is high, and low otherwise.
- Abort:
  - Sampled only in RUN; ignored in IDLE/DONE.
  - A pulse coincident with abort still appears (it is not suppressed).
  - If that pulse is the final one, `aborted=0` (normal completion).
- `cmd_*` inputs are ignored outside IDLE.

## Timing
- Accept at cycle A. Pulses occur in cycles A+P, A+2P, …, A+N·P.
- `done` occurs in cycle A+N·P+1. For N=0, `done` occurs in A+1 with no pulses.
- IDLE resumes in A+N·P+2, so the earliest next accept is there. Minimum command-to-command spacing is N·P+2.
- Abort sampled at the edge ending cycle B (in RUN): `done=1, aborted=1` in B+1, then IDLE in B+2.
- `busy` is high from A+1 through A+N·P.
- Reset values: state IDLE, counter 0, `pulse_idx` 0, `signal`/`busy`/`done`/`aborted` 0.
- `cmd_ready` is 0 while `reset` is high and 1 in the first cycle after release.
- Reset mid-burst aborts silently: no `done`.
- Arithmetic:
  - The counter compares against the latched P-1 at PERIOD_W bits. P=2^PERIOD_W-1 is the maximum.
  - `pulse_idx` wraps modulo 2^COUNT_W only in infinite mode.

## Configuration
- `PULSE_SEQ_INFINITE_EN`, when defined: `cmd_count==0` starts an unbounded burst.
  - Pulses continue every P cycles until `abort`.
  - The burst then ends with `done=1, aborted=1`.
  - `pulse_idx` wraps freely.
- When not defined: `cmd_count==0` is a zero-length burst. It gives `done` in A+1, `aborted=0`, and no pulses.

## Structure
- Package `pulse_seq_pkg` holds:
  - The state enum (IDLE, RUN, DONE).
  - Default widths PERIOD_W_DEF=8 and COUNT_W_DEF=8.
- Sub-module `pulse_period_timer` holds:
  - A runtime-period counter with inputs `clk`, `reset`, `clear`, `en`, and `period`.
  - Output `tick` when `cnt==period-1`.
  - The FSM drives `clear` on accept and `en` in RUN.

## Test plan
- Reset release, then P=5, N=3 accepted at A=10 → `signal` in cycles 15, 20, 25; `done=1, aborted=0` at 26; `pulse_idx=3`; `cmd_ready=1` at 27.
- P=0 and P=1, N=4 → four consecutive pulses A+1..A+4, `done` at A+5.
- P=4, N=10, abort at cycle A+9 → pulses at A+4 and A+8 only; `done=1, aborted=1` at A+10; `pulse_idx=2`.
- Abort in the same cycle as the final pulse (P=3, N=2, abort at A+6) → pulse at A+6 seen, `aborted=0`.
- `cmd_valid` held high during RUN with different P/N → ignored, original burst unaffected. Reset asserted at A+7 of a P=5, N=3 burst → no further pulses, no `done`, all outputs 0.
- N=0: without the macro → `done` at A+1, `signal` never high. With `PULSE_SEQ_INFINITE_EN` and P=2 → pulses every 2 cycles beyond 300 pulses (`pulse_idx` wraps past 255) until abort.
